instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction-fetch and PC-sequencing block that supplies each 32-bit instruction, and so the OPCODE field, to the control unit. It receives J and BEQ back from the control unit and ZERO from the ALU. It owns the PC and runs the read handshake to instruction memory. It stalls on data-memory busy and computes jump/branch targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
J  input  1  jump request from control unit; valid in EXEC.
BEQ  input  1  branch-if-equal request from control unit; valid in EXEC.
ZERO  input  1  ALU zero flag; valid in EXEC.
STALL  input  1  data-memory busywait; holds current instruction in EXEC.
IMEM_BUSYWAIT  input  1  instruction memory busy.
IMEM_READDATA  input  32  instruction word from memory.
IMEM_READ  output  1  registered read request.
IMEM_ADDRESS  output  32  equals PC.
PC  output  32  current program counter.
INSTRUCTION  output  32  registered fetched instruction.
OPCODE  output  8  INSTRUCTION[31:24], combinational slice.
INSTR_VALID  output  1  high while INSTRUCTION is being executed.

Behaviour:
- Clock/reset: one clock (CLK); RESET synchronous, active-high. No combinational path from inputs to registered outputs.
- Reset (any state, any cycle, including mid-handshake) sets:
  - state=IDLE, PC=RESET_PC, IMEM_READ=0, INSTRUCTION=32'h0, INSTR_VALID=0.
  - Any in-flight memory read is abandoned; late IMEM_READDATA is ignored.
- FSM states: IDLE, FETCH, WAIT, EXEC.
  - IDLE: next edge goes to FETCH; IMEM_READ<=1.
  - FETCH: request cycle; unconditionally goes to WAIT. IMEM_READ stays 1.
  - WAIT: if IMEM_BUSYWAIT=1, stay. If IMEM_BUSYWAIT=0:
    - INSTRUCTION<=IMEM_READDATA, IMEM_READ<=0, INSTR_VALID<=1, go to EXEC.
  - EXEC: if STALL=1, hold everything (PC, INSTRUCTION, INSTR_VALID=1). If STALL=0:
    - PC<=next_pc, INSTR_VALID<=0, IMEM_READ<=1, go to FETCH.
- Minimum 3 cycles per instruction (FETCH, WAIT, EXEC) with zero-wait memory and no stall.
- next_pc rules:
  - pc4 = PC + 4.
  - offset = INSTRUCTION[23:16], a signed word offset.
  - target = pc4 + {{22{offset[7]}}, offset, 2'b00}.
  - next_pc = target if J=1, or if BEQ=1 and ZERO=1; otherwise pc4.
  - J and BEQ both high: J wins. The target is identical, so this is defined only for determinism.
  - J/BEQ/ZERO are sampled only on the EXEC edge with STALL=0; ignored in all other states.
- Arithmetic: all 32-bit, modulo 2^32. PC wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- IMEM_ADDRESS = PC at all times and is stable throughout FETCH/WAIT.
- PC bits [1:0] are never written non-zero unless RESET_PC is misaligned; no alignment check.
- OPCODE is 8'h00 after reset. The downstream control unit must qualify it with INSTR_VALID.

Optional Feature:
Macro FETCH_BNE_EN.
- Defined:
  - Extra input port BNE (1 bit), sampled with J/BEQ in EXEC.
  - Branch is also taken when BNE=1 and ZERO=0.
  - Priority J > BEQ > BNE.
- Not defined:
  - No BNE port.
  - Branch condition is only J | (BEQ & ZERO).

Test Plan:
- Reset with RESET_PC=0, then RESET=0, zero-wait memory returning 32'h0000_0000 -> IMEM_READ rises 1 cycle after reset release. INSTR_VALID pulses every 3rd cycle. PC sequence 0,4,8,12.
- At PC=8, IMEM_READDATA=32'h06FE_0000 (J, offset -2), J=1 in EXEC -> next PC = 12 - 8 = 4.
- At PC=4, BEQ=1, ZERO=0, offset 8'h03 -> PC=8. Repeat with ZERO=1 -> PC=4+4+12=20.
- IMEM_BUSYWAIT held high 5 cycles in WAIT -> state stays WAIT, INSTR_VALID=0, IMEM_READ=1, PC unchanged. INSTRUCTION loads on the cycle busywait drops.
- STALL=1 for 3 cycles in EXEC with J=1 -> PC and INSTRUCTION held, INSTR_VALID=1. PC updates to the target on the first edge with STALL=0.
- Boundary and reset:
  - RESET_PC=32'hFFFF_FFFC, no branch -> next PC=32'h0000_0000.
  - RESET asserted mid-WAIT -> next edge gives PC=RESET_PC, IMEM_READ=0, INSTR_VALID=0, state IDLE.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// PC sequencing and instruction-memory read handshake feeding the control unit.
// Build option FETCH_BNE_EN adds a BNE input that branches when ZERO=0.
//   state   | meaning
//   S_IDLE  | out of reset, first read request issued on the next edge
//   S_FETCH | read request presented at IMEM_ADDRESS (= PC)
//   S_WAIT  | waiting for IMEM_BUSYWAIT to drop, then capture the word
//   S_EXEC  | INSTRUCTION valid; PC advances on the first edge with STALL=0
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        J,
  input  logic        BEQ,
  input  logic        ZERO,
  input  logic        STALL,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_READDATA,
`ifdef FETCH_BNE_EN
  input  logic        BNE,
`endif
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic [7:0]  OPCODE,
  output logic        INSTR_VALID
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        read_q, read_d;
  logic        valid_q, valid_d;

  logic [31:0] pc4, target, next_pc;
  logic [7:0]  offset;
  logic        take;

  // Every taken branch shares one target, so the condition is a plain OR.
  always_comb begin
    pc4    = pc_q + 32'd4;
    offset = instr_q[23:16];
    target = pc4 + {{22{offset[7]}}, offset, 2'b00};
    take   = J | (BEQ & ZERO);
`ifdef FETCH_BNE_EN
    take   = take | (BNE & ~ZERO);
`endif
    next_pc = take ? target : pc4;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    read_d  = read_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        read_d  = 1'b1;
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!IMEM_BUSYWAIT) begin
          instr_d = IMEM_READDATA;
          read_d  = 1'b0;
          valid_d = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!STALL) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          read_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      read_q  <= read_d;
      valid_q <= valid_d;
    end
  end

  assign IMEM_READ    = read_q;
  assign IMEM_ADDRESS = pc_q;
  assign PC           = pc_q;
  assign INSTRUCTION  = instr_q;
  assign OPCODE       = instr_q[31:24];
  assign INSTR_VALID  = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: driver predicts each executed (PC, word), monitor checks it.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, j, beq, zero, stall, busy, bne;
  logic [31:0] noise, rdata;
  logic        imem_read, instr_valid;
  logic [31:0] imem_address, pc, instruction;
  logic [7:0]  opcode;
  logic        w_read, w_valid;
  logic [31:0] w_address, w_pc, w_instruction;
  logic [7:0]  w_opcode;

  logic [31:0] mem [0:63];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          passes = 0;
  bit          abort = 1'b0;
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  // Memory returns garbage while busy so only the word present at busy release may be captured.
  assign rdata = busy ? noise : mem[imem_address[7:2]];

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .CLK(clk), .RESET(rst), .J(j), .BEQ(beq), .ZERO(zero), .STALL(stall),
    .IMEM_BUSYWAIT(busy), .IMEM_READDATA(rdata),
`ifdef FETCH_BNE_EN
    .BNE(bne),
`endif
    .IMEM_READ(imem_read), .IMEM_ADDRESS(imem_address), .PC(pc),
    .INSTRUCTION(instruction), .OPCODE(opcode), .INSTR_VALID(instr_valid)
  );

  instr_fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .CLK(clk), .RESET(rst), .J(1'b0), .BEQ(1'b0), .ZERO(1'b0), .STALL(1'b0),
    .IMEM_BUSYWAIT(1'b0), .IMEM_READDATA(32'h0),
`ifdef FETCH_BNE_EN
    .BNE(1'b0),
`endif
    .IMEM_READ(w_read), .IMEM_ADDRESS(w_address), .PC(w_pc),
    .INSTRUCTION(w_instruction), .OPCODE(w_opcode), .INSTR_VALID(w_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input bit jj, input bit bb, input bit zz, input bit nn);
    bit taken;
    bit bne_en;
    int off;
`ifdef FETCH_BNE_EN
    bne_en = 1'b1;
`else
    bne_en = 1'b0;
`endif
    off   = int'($signed(ins[23:16]));
    taken = jj || (bb && zz) || (bne_en && nn && !zz);
    return p + 32'd4 + (taken ? 32'(off * 4) : 32'd0);
  endfunction

  // Monitor: every new instruction entering execution must match the oldest prediction.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_v = 1'b0;
    else begin
      if (instr_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL scoreboard: unexpected instruction at pc %h, nothing predicted", pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pc", pc, mon_e.pc);
          check("instruction", instruction, mon_e.instr);
          check("opcode", {24'h0, opcode}, {24'h0, mon_e.instr[31:24]});
        end
      end
      prev_v = instr_valid;
    end
  end

  // Free-running instance starting at the top of the address space must wrap to zero.
  logic        w_prev = 1'b0;
  logic [31:0] w_exp = WRAP_PC;
  always @(negedge clk) begin
    if (rst) begin
      w_prev = 1'b0;
      w_exp  = WRAP_PC;
    end else begin
      if (w_valid && !w_prev) begin
        check("wrap_pc", w_pc, w_exp);
        check("wrap_addr", w_address, w_exp);
        check("wrap_instr", w_instruction | {23'h0, w_read, w_opcode}, 32'h0);
        w_exp = w_exp + 32'd4;
      end
      w_prev = w_valid;
    end
  end

  // Called at the negedge just before the edge that leaves IDLE or EXEC.
  task automatic run_instr(input int busy_hold, input int stalls,
                           input bit jj, input bit bb, input bit zz, input bit nn);
    int          cnt;
    int          exp_cnt;
    logic [31:0] cur_instr;
    if (abort) return;
    cnt   = 0;
    busy  = (busy_hold > 0);
    noise = $urandom;
    forever begin
      @(negedge clk);
      if (instr_valid) break;
      cnt++;
      check("wait_pc", pc, model_pc);
      check("wait_read", {31'h0, imem_read}, 32'd1);
      j     = 1'($urandom);
      beq   = 1'($urandom);
      zero  = 1'($urandom);
      bne   = 1'($urandom);
      stall = 1'($urandom);
      busy  = (cnt < busy_hold);
      noise = $urandom;
      if (cnt > 40) begin
        checks++;
        $display("FAIL wait_timeout: INSTR_VALID not seen after %0d cycles, required within 40", cnt);
        abort = 1'b1;
        return;
      end
    end
    exp_cnt = (busy_hold > 2) ? busy_hold : 2;
    check("latency", cnt, exp_cnt);
    check("exec_read", {31'h0, imem_read}, 32'd0);
    busy      = 1'b0;
    cur_instr = mem_at(model_pc);
    for (int s = 0; s < stalls; s++) begin
      stall = 1'b1;
      j     = 1'($urandom);
      beq   = 1'($urandom);
      zero  = 1'($urandom);
      bne   = 1'($urandom);
      @(negedge clk);
      check("stall_valid", {31'h0, instr_valid}, 32'd1);
      check("stall_pc", pc, model_pc);
      check("stall_instr", instruction, cur_instr);
    end
    stall = 1'b0;
    j     = jj;
    beq   = bb;
    zero  = zz;
    bne   = nn;
    model_pc = ref_next(model_pc, cur_instr, jj, bb, zz, nn);
    exp_q.push_back('{pc: model_pc, instr: mem_at(model_pc)});
  endtask

  initial begin
    rst = 1'b1; j = 1'b0; beq = 1'b0; zero = 1'b0; bne = 1'b0;
    stall = 1'b0; busy = 1'b0; noise = 32'h0;
    foreach (mem[i]) mem[i] = $urandom;
    mem[1] = 32'h0403_0000;
    mem[2] = 32'h06FE_0000;
    mem[3] = 32'h00FD_0000;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, RST_PC);
    check("rst_read", {31'h0, imem_read}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'd0);
    check("rst_opcode", {24'h0, opcode}, 32'h0);
    model_pc = RST_PC;
    exp_q.push_back('{pc: RST_PC, instr: mem_at(RST_PC)});
    rst = 1'b0;

    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // 0 -> 4
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // 4 -> 8
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // 8 -> 12
    run_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);  // 12, J offset -3 -> 4
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // 4 -> 8
    run_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);  // 8, J offset -2 -> 4
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);  // 4, BEQ not taken -> 8
    run_instr(0, 3, 1'b1, 1'b0, 1'b0, 1'b0);  // 8, stalled 3 cycles, J -> 4
    run_instr(7, 0, 1'b0, 1'b1, 1'b1, 1'b0);  // 4, BEQ taken -> 20
    run_instr(7, 0, 1'b0, 1'b0, 1'b0, 1'b0);  // busywait 5 WAIT cycles at 20

    for (int n = 0; n < 150; n++)
      run_instr($urandom_range(0, 6), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    if (!abort) begin
      busy = 1'b1;
      repeat (3) @(negedge clk);
      check("midwait_valid", {31'h0, instr_valid}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("midwait_rst_pc", pc, RST_PC);
      check("midwait_rst_read", {31'h0, imem_read}, 32'd0);
      check("midwait_rst_valid", {31'h0, instr_valid}, 32'd0);
      check("midwait_rst_instr", instruction, 32'h0);
      exp_q.delete();
      model_pc = RST_PC;
      exp_q.push_back('{pc: RST_PC, instr: mem_at(RST_PC)});
      busy = 1'b0;
      rst  = 1'b0;
    end

    for (int n = 0; n < 30; n++)
      run_instr($urandom_range(0, 6), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
